// File: rtl/rx_mac.sv
// rx_mac: 64-bit XGMII receive MAC to AXI-Stream.
// Checks and strips preamble/SFD, realigns lane-4 starts onto lane 0,
// finds Terminate to build tlast/tkeep, and flags errored frames on tuser.
// The stream cannot be stalled: a beat refused by the user is lost and the
// frame is marked bad.
module rx_mac #(
   parameter int MAX_FRAME_BYTES = 1518
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic [63:0] xgmii_rxd,
   input  logic [7:0]  xgmii_rxc,
   input  logic        phy_rx_valid,
   output logic [63:0] m00_axis_tdata,
   output logic [7:0]  m00_axis_tkeep,
   output logic        m00_axis_tvalid,
   input  logic        m00_axis_tready,
   output logic        m00_axis_tlast,
   output logic        m00_axis_tuser
);

   localparam logic [7:0]  C_START = 8'hFB;
   localparam logic [7:0]  C_TERM  = 8'hFD;
   localparam logic [7:0]  C_PRE   = 8'h55;
   localparam logic [7:0]  C_SFD   = 8'hD5;
   localparam logic [11:0] C_MAX   = 12'(MAX_FRAME_BYTES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREAMBLE,
      S_DATA,
      S_FLUSH,
      S_DROP
   } state_t;

   state_t r_state, w_nstate;

   // staged beat: the one waiting for the next word before it may leave
   logic [63:0] r_stg_data, w_stg_data;
   logic [7:0]  r_stg_keep, w_stg_keep;
   logic        r_stg_last, w_stg_last;
   logic        r_stg_vld,  w_stg_vld;
   // tail beat: second pending beat after a late Terminate (always a tlast beat)
   logic [63:0] r_tail_data, w_tail_data;
   logic [7:0]  r_tail_keep, w_tail_keep;
   logic        r_tail_vld,  w_tail_vld;
   // upper half of the previous word in shifted (lane-4 start) mode
   logic [31:0] r_hold, w_hold;
   logic        r_shift, w_shift;
   logic        r_err, w_err;
   logic        r_drop, w_drop;      // go to DROP instead of IDLE once flushed
   logic [10:0] r_cnt, w_cnt;

   // output beat being launched this cycle
   logic [63:0] w_o_data;
   logic [7:0]  w_o_keep;
   logic        w_o_vld, w_o_last, w_o_user;

   // word decode
   logic        w_sop0, w_sop4, w_sfd;
   logic        w_term_hit, w_start_in, w_ctl_err;
   logic [2:0]  w_term_k;
   logic [11:0] w_left;
   logic [3:0]  w_room, w_nb, w_end_k;
   logic        w_trunc, w_lost, w_err_base, w_cur_err;

   // keep mask for the lowest n bytes (n = 0..8)
   function automatic logic [7:0] f_keep(input logic [3:0] n);
      logic [7:0] k;
      k = '0;
      for (int i = 0; i < 8; i++)
         if (4'(i) < n) k[i] = 1'b1;
      return k;
   endfunction

   // expand a byte keep into a bit mask
   function automatic logic [63:0] f_mask(input logic [7:0] k);
      logic [63:0] m;
      m = '0;
      for (int i = 0; i < 8; i++)
         m[8*i +: 8] = {8{k[i]}};
      return m;
   endfunction

   assign w_sop0 = (xgmii_rxc == 8'h01) && (xgmii_rxd[7:0] == C_START) &&
                   (xgmii_rxd[55:8] == {6{C_PRE}}) && (xgmii_rxd[63:56] == C_SFD);
   assign w_sop4 = (xgmii_rxc[7:4] == 4'h1) && (xgmii_rxd[39:32] == C_START) &&
                   (xgmii_rxd[63:40] == {3{C_PRE}});
   assign w_sfd  = (xgmii_rxc[3:0] == 4'h0) && (xgmii_rxd[23:0] == {3{C_PRE}}) &&
                   (xgmii_rxd[31:24] == C_SFD);

   // a refused beat is gone for good; it poisons the frame it belongs to
   assign w_lost     = m00_axis_tvalid & ~m00_axis_tready;
   assign w_err_base = r_err | w_lost;

   // first Terminate lane, plus Start / stray control lanes ahead of it
   always_comb begin
      w_term_hit = 1'b0;
      w_term_k   = 3'd0;
      for (int i = 7; i >= 0; i--)
         if (xgmii_rxc[i] && (xgmii_rxd[8*i +: 8] == C_TERM)) begin
            w_term_hit = 1'b1;
            w_term_k   = 3'(i);
         end
      w_start_in = 1'b0;
      w_ctl_err  = 1'b0;
      for (int i = 0; i < 8; i++)
         if (!w_term_hit || (3'(i) < w_term_k)) begin
            if (xgmii_rxc[i]) w_ctl_err = 1'b1;
            if (xgmii_rxc[i] && (xgmii_rxd[8*i +: 8] == C_START)) w_start_in = 1'b1;
         end
   end

   // length limit: a word that overruns the limit ends the frame as if a
   // Terminate sat at the first byte past the limit
   always_comb begin
      w_left  = (12'(r_cnt) >= C_MAX) ? 12'd0 : (C_MAX - 12'(r_cnt));
      w_room  = (w_left >= 12'd8) ? 4'd8 : w_left[3:0];
      w_nb    = w_term_hit ? {1'b0, w_term_k} : 4'd8;
      w_trunc = !w_start_in && (w_nb > w_room);
      w_end_k = w_start_in ? 4'd0 : (w_trunc ? w_room : {1'b0, w_term_k});
      w_cur_err = w_err_base | w_ctl_err | w_trunc;
   end

   // next state, beat staging and output launch
   always_comb begin
      w_nstate    = r_state;
      w_o_vld     = 1'b0;
      w_o_data    = r_stg_data;
      w_o_keep    = r_stg_keep;
      w_o_last    = 1'b0;
      w_o_user    = 1'b0;
      w_stg_data  = r_stg_data;
      w_stg_keep  = r_stg_keep;
      w_stg_last  = r_stg_last;
      w_stg_vld   = r_stg_vld;
      w_tail_data = r_tail_data;
      w_tail_keep = r_tail_keep;
      w_tail_vld  = r_tail_vld;
      w_hold      = r_hold;
      w_shift     = r_shift;
      w_drop      = r_drop;
      w_err       = w_err_base;
      w_cnt       = r_cnt;

      unique case (r_state)
         S_IDLE: begin
            if (phy_rx_valid && (w_sop0 || w_sop4)) begin
               w_nstate   = w_sop0 ? S_DATA : S_PREAMBLE;
               w_shift    = ~w_sop0;
               w_err      = 1'b0;
               w_drop     = 1'b0;
               w_cnt      = '0;
               w_stg_vld  = 1'b0;
               w_tail_vld = 1'b0;
            end
         end

         S_PREAMBLE: begin
            if (phy_rx_valid) begin
               if (w_sfd) begin
                  w_hold   = xgmii_rxd[63:32];
                  w_cnt    = 11'd4;
                  w_nstate = S_DATA;
               end else begin
                  w_nstate = S_IDLE;
               end
            end
         end

         S_DATA: begin
            if (phy_rx_valid) begin
               // the next word is known, so the staged beat can leave now
               w_o_vld = r_stg_vld;
               w_err   = w_cur_err;
               if (w_start_in || w_term_hit || w_trunc) begin
                  w_drop     = w_start_in | w_trunc;
                  w_stg_vld  = 1'b1;
                  w_stg_last = 1'b1;
                  w_nstate   = S_FLUSH;
                  if (!r_shift) begin
                     if (w_end_k == 4'd0) begin
                        // nothing left in this word: staged beat is the last
                        w_o_last  = 1'b1;
                        w_o_user  = w_cur_err;
                        w_stg_vld = 1'b0;
                        w_nstate  = w_drop ? S_DROP : S_IDLE;
                     end else begin
                        w_stg_data = xgmii_rxd;
                        w_stg_keep = f_keep(w_end_k);
                     end
                  end else if (w_end_k <= 4'd4) begin
                     w_stg_data = {xgmii_rxd[31:0], r_hold};
                     w_stg_keep = f_keep(w_end_k + 4'd4);
                  end else begin
                     // end past lane 4: one full beat, then a short tail
                     w_stg_data  = {xgmii_rxd[31:0], r_hold};
                     w_stg_keep  = 8'hFF;
                     w_stg_last  = 1'b0;
                     w_tail_data = {32'd0, xgmii_rxd[63:32]};
                     w_tail_keep = f_keep(w_end_k - 4'd4);
                     w_tail_vld  = 1'b1;
                  end
               end else begin
                  w_stg_vld  = 1'b1;
                  w_stg_last = 1'b0;
                  w_stg_keep = 8'hFF;
                  w_stg_data = r_shift ? {xgmii_rxd[31:0], r_hold} : xgmii_rxd;
                  if (r_shift) w_hold = xgmii_rxd[63:32];
                  w_cnt = (r_cnt >= 11'd2040) ? 11'h7FF : (r_cnt + 11'd8);
               end
            end
         end

         S_FLUSH: begin
            // drains independently of phy_rx_valid; input is not consumed
            w_o_vld  = r_stg_vld;
            w_o_last = r_stg_last;
            w_o_user = r_stg_last & w_err_base;
            if (r_tail_vld) begin
               w_stg_data = r_tail_data;
               w_stg_keep = r_tail_keep;
               w_stg_last = 1'b1;
               w_stg_vld  = 1'b1;
               w_tail_vld = 1'b0;
            end else begin
               w_stg_vld = 1'b0;
               w_nstate  = r_drop ? S_DROP : S_IDLE;
            end
         end

         S_DROP: begin
            if (phy_rx_valid && (w_term_hit || (xgmii_rxc == 8'hFF)))
               w_nstate = S_IDLE;
         end

         default: w_nstate = S_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) r_state <= S_IDLE;
      else            r_state <= w_nstate;
   end

   // datapath holding registers and registered AXI-Stream outputs
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_stg_data      <= '0;
         r_stg_keep      <= '0;
         r_stg_last      <= 1'b0;
         r_stg_vld       <= 1'b0;
         r_tail_data     <= '0;
         r_tail_keep     <= '0;
         r_tail_vld      <= 1'b0;
         r_hold          <= '0;
         r_shift         <= 1'b0;
         r_err           <= 1'b0;
         r_drop          <= 1'b0;
         r_cnt           <= '0;
         m00_axis_tdata  <= '0;
         m00_axis_tkeep  <= '0;
         m00_axis_tvalid <= 1'b0;
         m00_axis_tlast  <= 1'b0;
         m00_axis_tuser  <= 1'b0;
      end else begin
         r_stg_data      <= w_stg_data;
         r_stg_keep      <= w_stg_keep;
         r_stg_last      <= w_stg_last;
         r_stg_vld       <= w_stg_vld;
         r_tail_data     <= w_tail_data;
         r_tail_keep     <= w_tail_keep;
         r_tail_vld      <= w_tail_vld;
         r_hold          <= w_hold;
         r_shift         <= w_shift;
         r_err           <= w_err;
         r_drop          <= w_drop;
         r_cnt           <= w_cnt;
         m00_axis_tvalid <= w_o_vld;
         m00_axis_tdata  <= w_o_vld ? (w_o_data & f_mask(w_o_keep)) : '0;
         m00_axis_tkeep  <= w_o_vld ? w_o_keep : '0;
         m00_axis_tlast  <= w_o_vld & w_o_last;
         m00_axis_tuser  <= w_o_vld & w_o_last & w_o_user;
      end
   end

endmodule

// File: tb/tb_rx_mac.sv
// tb_rx_mac: directed bench for rx_mac. Frames are built as byte/ctrl
// streams, packed into XGMII words, and the received beats are compared
// against a byte-level model of the expected AXI-Stream frame.
module tb_rx_mac;
   localparam int MAXB = 1518;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic [63:0] rxd    = '0;
   logic [7:0]  rxc    = 8'hFF;
   logic        rx_vld = 1'b0;
   logic        tready = 1'b1;
   logic [63:0] tdata;
   logic [7:0]  tkeep;
   logic        tvalid, tlast, tuser;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   typedef struct {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
      logic        u;
      int          c;
   } beat_t;

   beat_t      got[$];
   logic [8:0] strm[$];   // {ctrl, byte} in wire order
   logic [7:0] pay[$];    // expected payload bytes

   rx_mac #(.MAX_FRAME_BYTES(MAXB)) dut (
      .i_clk           (clk),
      .i_reset_n       (rst_n),
      .xgmii_rxd       (rxd),
      .xgmii_rxc       (rxc),
      .phy_rx_valid    (rx_vld),
      .m00_axis_tdata  (tdata),
      .m00_axis_tkeep  (tkeep),
      .m00_axis_tvalid (tvalid),
      .m00_axis_tready (tready),
      .m00_axis_tlast  (tlast),
      .m00_axis_tuser  (tuser)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // accepted beats, sampled mid-cycle
   always @(negedge clk)
      if (tvalid && tready)
         got.push_back('{d: tdata, k: tkeep, l: tlast, u: tuser, c: cyc});

   function automatic logic [63:0] kmask(input logic [7:0] k);
      logic [63:0] m;
      m = '0;
      for (int i = 0; i < 8; i++)
         if (k[i]) m[8*i +: 8] = 8'hFF;
      return m;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic build(input bit sh, input int len, input int seed);
      strm.delete();
      pay.delete();
      if (sh) repeat (4) strm.push_back({1'b1, 8'h07});
      strm.push_back({1'b1, 8'hFB});
      repeat (6) strm.push_back({1'b0, 8'h55});
      strm.push_back({1'b0, 8'hD5});
      for (int j = 0; j < len; j++) begin
         logic [7:0] b;
         b = 8'(j * 13 + seed);
         pay.push_back(b);
         strm.push_back({1'b0, b});
      end
      strm.push_back({1'b1, 8'hFD});
      while (strm.size() % 8 != 0) strm.push_back({1'b1, 8'h07});
   endtask

   task automatic idle(input int n);
      rx_vld = 1'b1;
      rxc    = 8'hFF;
      rxd    = {8{8'h07}};
      tready = 1'b1;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // gaps: invalid garbage word before every odd word; drop_w: tready low
   // while word drop_w is presented; acc_cyc: cycle count after word acc_w
   task automatic send(input bit gaps, input int drop_w, input int acc_w,
                       input int nw, output int acc_cyc);
      int nwords;
      nwords  = (nw < 0) ? (strm.size() / 8) : nw;
      acc_cyc = -1;
      for (int w = 0; w < nwords; w++) begin
         if (gaps && (w % 2 == 1)) begin
            rx_vld = 1'b0;
            rxc    = 8'hFF;
            rxd    = {8{8'hFB}};
            tready = 1'b1;
            @(posedge clk);
            #1;
         end
         for (int l = 0; l < 8; l++) begin
            rxd[8*l +: 8] = strm[8*w + l][7:0];
            rxc[l]        = strm[8*w + l][8];
         end
         rx_vld = 1'b1;
         tready = (w != drop_w);
         @(posedge clk);
         #1;
         if (w == acc_w) acc_cyc = cyc;
      end
      tready = 1'b1;
   endtask

   task automatic check_frame(input string tag, input bit exp_u, input int lost);
      beat_t ex[$];
      int    n;
      n = (pay.size() > MAXB) ? MAXB : pay.size();
      for (int b = 0; b * 8 < n; b++) begin
         beat_t e;
         e.d = '0;
         e.k = '0;
         e.c = 0;
         for (int l = 0; l < 8; l++)
            if (b * 8 + l < n) begin
               e.d[8*l +: 8] = pay[b * 8 + l];
               e.k[l]        = 1'b1;
            end
         e.l = (b * 8 + 8 >= n);
         e.u = e.l & exp_u;
         ex.push_back(e);
      end
      if (lost >= 0) ex.delete(lost);
      chk({tag, " beats"}, 64'(got.size()), 64'(ex.size()));
      for (int i = 0; i < got.size() && i < ex.size(); i++) begin
         chk($sformatf("%s b%0d data", tag, i), got[i].d & kmask(got[i].k), ex[i].d);
         chk($sformatf("%s b%0d keep", tag, i), 64'(got[i].k), 64'(ex[i].k));
         chk($sformatf("%s b%0d last", tag, i), 64'(got[i].l), 64'(ex[i].l));
         chk($sformatf("%s b%0d user", tag, i), 64'(got[i].u), 64'(ex[i].u));
      end
      got.delete();
   endtask

   initial begin
      int t0;
      int nl;

      // reset state
      idle(3);
      chk("rst tvalid", 64'(tvalid), 64'd0);
      chk("rst tlast",  64'(tlast),  64'd0);
      chk("rst tuser",  64'(tuser),  64'd0);
      chk("rst tkeep",  64'(tkeep),  64'd0);
      chk("rst tdata",  tdata,       64'd0);
      rst_n = 1'b1;
      idle(2);

      // lane-0 start, 64 bytes, Terminate lane 0; latency N+2
      build(1'b0, 64, 1);
      send(1'b0, -1, 1, -1, t0);
      idle(6);
      chk("t1 first beat cycle", (got.size() > 0) ? 64'(got[0].c) : 64'hFFFF, 64'(t0 + 1));
      check_frame("t1", 1'b0, -1);

      // lane-4 start, 60 bytes, Terminate lane 0 -> final keep 0x0F
      build(1'b1, 60, 2);
      send(1'b0, -1, -1, -1, t0);
      idle(6);
      check_frame("t2", 1'b0, -1);

      // shifted, Terminate lane 6 -> full beat then keep 0x03; same with gaps
      build(1'b1, 34, 3);
      send(1'b0, -1, -1, -1, t0);
      idle(6);
      check_frame("t3", 1'b0, -1);
      send(1'b1, -1, -1, -1, t0);
      idle(6);
      check_frame("t3 gaps", 1'b0, -1);

      // Error char in lane 3 mid-frame, then a clean frame
      build(1'b0, 40, 4);
      strm[19] = {1'b1, 8'hFE};
      pay[11]  = 8'hFE;
      send(1'b0, -1, -1, -1, t0);
      idle(6);
      check_frame("t4 err", 1'b1, -1);
      build(1'b0, 24, 5);
      send(1'b0, -1, -1, -1, t0);
      idle(6);
      check_frame("t4 clean", 1'b0, -1);

      // bad preamble: nothing out; following frame normal
      build(1'b0, 16, 6);
      strm[2] = {1'b0, 8'h54};
      send(1'b0, -1, -1, -1, t0);
      idle(6);
      chk("t5 bad preamble beats", 64'(got.size()), 64'd0);
      got.delete();
      build(1'b0, 16, 7);
      send(1'b0, -1, -1, -1, t0);
      idle(6);
      check_frame("t5 good", 1'b0, -1);

      // oversize frame truncated at MAXB bytes
      build(1'b0, 1600, 8);
      send(1'b0, -1, -1, -1, t0);
      idle(6);
      check_frame("t6 trunc", 1'b1, -1);

      // tready low while beat 0 is presented -> beat 0 lost, tuser on tlast
      build(1'b0, 32, 9);
      send(1'b0, 3, -1, -1, t0);
      idle(6);
      check_frame("t7 bp", 1'b1, 0);

      // reset mid-frame: outputs clear, no tlast, next frame clean
      build(1'b0, 32, 10);
      send(1'b0, -1, -1, 4, t0);
      rst_n = 1'b0;
      idle(1);
      chk("t8 rst tvalid", 64'(tvalid), 64'd0);
      chk("t8 rst tlast",  64'(tlast),  64'd0);
      chk("t8 rst tuser",  64'(tuser),  64'd0);
      chk("t8 rst tkeep",  64'(tkeep),  64'd0);
      chk("t8 rst tdata",  tdata,       64'd0);
      rst_n = 1'b1;
      idle(6);
      nl = 0;
      foreach (got[i]) if (got[i].l) nl++;
      chk("t8 aborted tlast count", 64'(nl), 64'd0);
      got.delete();
      build(1'b1, 20, 11);
      send(1'b0, -1, -1, -1, t0);
      idle(6);
      check_frame("t8 after", 1'b0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rx_mac.md
Name: rx_mac

Overview:
- Receive-side MAC: consumes 64-bit XGMII words from the PHY Rx path and produces a user AXI-Stream, one frame per packet.
- Detects Start, checks and strips preamble/SFD, realigns lane-4 starts to lane 0, and finds Terminate to generate tlast/tkeep.
- Flags errored frames on m00_axis_tuser.
- Instantiated in mac alongside tx_mac, on the i_rxc domain; the FCS is passed through to the user (no CRC check in this block).

Parameters:
- MAX_FRAME_BYTES, 1518, payload-plus-FCS byte limit; beyond it the frame is truncated and flagged.

Ports:
- i_clk  in  1  Rx clock (i_rxc in mac).
- i_reset_n  in  1  synchronous, active-low reset.
- xgmii_rxd  in  64  lane i = bits [8i+7:8i]; lane 0 is first on the wire.
- xgmii_rxc  in  8  bit i = 1 means lane i is a control character.
- phy_rx_valid  in  1  word valid; words with phy_rx_valid=0 are ignored entirely (no state change).
- m00_axis_tdata  out  64  payload bytes, byte 0 in [7:0].
- m00_axis_tkeep  out  8  contiguous from bit 0.
- m00_axis_tvalid  out  1  beat valid.
- m00_axis_tready  in  1  user ready (stream is not stallable, see below).
- m00_axis_tlast  out  1  last beat of frame.
- m00_axis_tuser  out  1  frame error, meaningful only on the tlast beat.

Behaviour:
- Reset (i_reset_n=0 at posedge): state=IDLE; all outputs 0; holding registers cleared. Reset mid-frame discards the frame with no tlast emitted.
- Characters:
  - Start = 0xFB (ctrl), Terminate = 0xFD (ctrl), Error = 0xFE (ctrl).
  - Preamble = 0x55 ×6 then SFD = 0xD5.
- IDLE:
  - Start in lane 0 with rxc=0x01, lanes 1–6 = 0x55, lane 7 = 0xD5 → DATA, aligned mode.
  - Start in lane 4 with rxc[7:4]=0x1, lanes 5–7 = 0x55 → PREAMBLE.
  - Any other word, including a malformed preamble → stay IDLE; no output.
- PREAMBLE (next valid word):
  - Required: rxc[3:0]=0, lanes 0–2 = 0x55, lane 3 = 0xD5. Then capture lanes 4–7 as the first 4 payload bytes into the hold register → DATA, shifted mode.
  - Any mismatch → IDLE, frame silently dropped.
- DATA, aligned mode: the payload word is the input word.
- DATA, shifted mode: the payload word is {cur[31:0], hold[31:0]}, and hold ← cur[63:32].
- Output pipeline: one staged beat.
  - A beat is emitted only once the next valid input word is known, so tlast lands on the correct beat.
  - With phy_rx_valid held high, a payload word accepted at cycle N appears on m00_axis_* at cycle N+2.
  - Registered outputs; tvalid is high for exactly one cycle per beat.
- Terminate in lane k (first ctrl lane of the word):
  - Aligned, k=0: the staged beat gets tlast, tkeep=0xFF.
  - Aligned, k>0: the staged beat is emitted, then a final beat with tkeep=(1<<k)-1 and tlast.
  - Shifted, k≤4: final beat = {cur lanes 0..k-1, hold}, tkeep=(1<<(4+k))-1, tlast.
  - Shifted, k>4: a full beat (tkeep=0xFF), then FLUSH emits the last beat with tkeep=(1<<(k-4))-1 and tlast.
  - State returns to IDLE after the tlast beat.
- Errors (set tuser=1 on the frame's tlast beat):
  - Any ctrl lane other than a first Terminate inside the frame, including Error chars.
  - Start in frame: end the current frame using the staged/hold bytes as the tlast beat, then enter DROP.
  - Byte count > MAX_FRAME_BYTES: the truncated beat is emitted with tlast and tuser=1, then DROP.
  - Backpressure loss (below).
- DROP: ignore input until a word containing Terminate or all-Idle ctrl (rxc=0xFF), then → IDLE.
- Backpressure:
  - XGMII cannot stall, so the block never holds data for the user.
  - If tvalid=1 and tready=0, the beat is lost and a sticky error sets tuser=1 on that frame's tlast.
  - If the lost beat is the tlast beat itself, no tlast is delivered.
- Byte counter: 11 bits, saturating, cleared at each Start.
- Minimum/runt length is not checked here.

Test Plan:
- Lane-0 Start, 64-byte frame (8 data words), Terminate at lane 0 of the following word → 8 beats tkeep=0xFF, tlast on beat 8, tuser=0, first beat at cycle N+2.
- Lane-4 Start, 60 payload bytes, Terminate lane 0 → 7 beats of 0xFF plus a final beat tkeep=0x0F, tlast, bytes byte-exact vs reference.
- Shifted mode, Terminate at lane 6 → full beat, then extra beat tkeep=0x03 with tlast; phy_rx_valid toggled 0/1 mid-frame yields identical output.
- Error char 0xFE in lane 3 mid-frame → frame delivered with tuser=1 on tlast; the next clean frame has tuser=0.
- Preamble lane 2 = 0x54 → no output; the following good frame is received normally. A 1600-byte frame → truncated at 1518 bytes with tlast and tuser=1.
- tready=0 for one beat mid-frame → tuser=1 on tlast. Reset asserted mid-frame → outputs 0 next cycle; a new frame after release is clean.
